// File: rtl/wb_stage_buffered_if.sv
// wb_stage_buffered_if: memory-stage handshake and register-file write port of the writeback stage
//   in_valid/in_ready        upstream handshake
//   in_opcode..in_pc         retiring instruction fields
//   rf_we/rf_addr/rf_data    register-file write request (head of buffer)
//   rf_ready                 register file accepts the write this cycle
//   master: memory stage + register file side; slave: writeback stage side
interface wb_stage_buffered_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 5,
    parameter int OP_W    = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_opcode;
    logic [DATA_W-1:0]  in_alu;
    logic [DATA_W-1:0]  in_lmd;
    logic [1:0]         in_size;
    logic               in_unsigned;
    logic [RADDR_W-1:0] in_dest;
    logic [PC_W-1:0]    in_pc;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]  rf_data;
    logic               rf_ready;

    modport master (
        output in_valid, in_opcode, in_alu, in_lmd, in_size, in_unsigned, in_dest, in_pc, rf_ready,
        input  in_ready, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  in_valid, in_opcode, in_alu, in_lmd, in_size, in_unsigned, in_dest, in_pc, rf_ready,
        output in_ready, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/wb_stage_buffered.sv
// wb_stage_buffered: buffered writeback stage with in-order queue, RF backpressure and retire counter
//   clk, rst (async, active-low), flush (sync, drops all buffered entries)
//   bus          : upstream handshake + register-file write port (slave modport)
//   fwd_*        : head entry for forwarding (fwd_valid == rf_we)
//   out_pc/out_opcode : last retired entry; retire_count : wrapping retire counter
module wb_stage_buffered #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 5,
    parameter int OP_W    = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    parameter logic [OP_W-1:0] OP_NOP  = '0,
    parameter logic [OP_W-1:0] OP_ARSH = OP_W'(8),
    parameter logic [OP_W-1:0] OP_LDW  = OP_W'(9)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    wb_stage_buffered_if.slave  bus,
    output logic                fwd_valid,
    output logic [RADDR_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [PC_W-1:0]     out_pc,
    output logic [OP_W-1:0]     out_opcode,
    output logic [CNT_W-1:0]    retire_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [RADDR_W-1:0] dest_q [DEPTH];
    logic [PC_W-1:0]    pc_q   [DEPTH];
    logic [OP_W-1:0]    op_q   [DEPTH];
    logic [DEPTH-1:0]   wr_q;
    logic [AW-1:0]      rd_q, rd_d, wp_q, wp_d;
    logic [AW:0]        occ_q, occ_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic               empty, head_wr, enq, deq, is_alu, in_wr, sx_b, sx_h;
    logic [DATA_W-1:0]  lmd_ext, in_data;

    always_comb begin
        sx_b    = bus.in_lmd[7] & ~bus.in_unsigned;
        sx_h    = bus.in_lmd[15] & ~bus.in_unsigned;
        lmd_ext = bus.in_size == 2'b10 ? {{(DATA_W-8){sx_b}}, bus.in_lmd[7:0]} :
                  bus.in_size == 2'b01 ? {{(DATA_W-16){sx_h}}, bus.in_lmd[15:0]} : bus.in_lmd;
        is_alu  = bus.in_opcode > OP_NOP && bus.in_opcode <= OP_ARSH;
        in_wr   = is_alu | (bus.in_opcode == OP_LDW);
        in_data = bus.in_opcode == OP_LDW ? lmd_ext : bus.in_alu;
        empty   = occ_q == '0;
        head_wr = ~empty & wr_q[rd_q];
        // occupancy MSB set means occupancy == DEPTH (power of two)
        enq     = ~flush & bus.in_valid & ~occ_q[AW] & (bus.in_opcode != OP_NOP);
        // non-writing heads retire unconditionally; writing heads wait for the RF
        deq     = ~flush & ~empty & (~wr_q[rd_q] | bus.rf_ready);
        rd_d    = flush ? '0 : deq ? rd_q + AW'(1) : rd_q;
        wp_d    = flush ? '0 : enq ? wp_q + AW'(1) : wp_q;
        occ_d   = flush ? '0 : occ_q + (AW+1)'(enq) - (AW+1)'(deq);
        cnt_d   = deq ? cnt_q + CNT_W'(1) : cnt_q;
        out_pc_d = deq ? pc_q[rd_q] : out_pc_q;
        out_op_d = deq ? op_q[rd_q] : out_op_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dest_q[i] <= '0;
                pc_q[i]   <= '0;
                op_q[i]   <= '0;
            end
            wr_q     <= '0;
            rd_q     <= '0;
            wp_q     <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            out_pc_q <= '0;
            out_op_q <= '0;
        end else begin
            if (enq) begin
                data_q[wp_q] <= in_data;
                dest_q[wp_q] <= bus.in_dest;
                pc_q[wp_q]   <= bus.in_pc;
                op_q[wp_q]   <= bus.in_opcode;
                wr_q[wp_q]   <= in_wr;
            end
            rd_q     <= rd_d;
            wp_q     <= wp_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            out_pc_q <= out_pc_d;
            out_op_q <= out_op_d;
        end
    end

    assign bus.in_ready = ~occ_q[AW];
    assign bus.rf_we    = head_wr;
    assign bus.rf_addr  = dest_q[rd_q];
    assign bus.rf_data  = data_q[rd_q];
    assign fwd_valid    = head_wr;
    assign fwd_addr     = dest_q[rd_q];
    assign fwd_data     = data_q[rd_q];
    assign out_pc       = out_pc_q;
    assign out_opcode   = out_op_q;
    assign retire_count = cnt_q;
endmodule

// File: tb/tb_wb_stage_buffered.sv
// tb_wb_stage_buffered: directed stimulus with a queue-based scoreboard on the RF write port
module tb_wb_stage_buffered;
    localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, SUB = 5'd2, OR = 5'd4, XOR = 5'd5, LDW = 5'd9, STR = 5'd10;

    logic       clk = 0, rst = 0, flush = 0;
    logic       fwd_valid;
    logic [3:0] fwd_addr;
    logic [31:0] fwd_data;
    logic [4:0] out_pc, out_opcode;
    logic [3:0] retire_count;
    int passed = 0, total = 0;
    logic [35:0] exp_q[$];

    wb_stage_buffered_if #(.DATA_W(32), .RADDR_W(4), .PC_W(5), .OP_W(5)) bus ();

    wb_stage_buffered #(.DATA_W(32), .RADDR_W(4), .PC_W(5), .OP_W(5), .DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_pc(out_pc), .out_opcode(out_opcode), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // scoreboard monitor: every RF write that the RF accepts must match the oldest expected write
    always @(negedge clk) begin
        if (rst && bus.rf_we && bus.rf_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL rf_write_unexpected: got addr=%0d data=0x%0h expected none", bus.rf_addr, bus.rf_data);
            end else check("rf_write", {28'd0, bus.rf_addr, bus.rf_data}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] lmd,
                         input logic [1:0] sz, input logic un, input logic [3:0] dst, input logic [4:0] pc,
                         input logic expw, input logic [31:0] expd);
        bus.in_opcode = op; bus.in_alu = alu; bus.in_lmd = lmd; bus.in_size = sz;
        bus.in_unsigned = un; bus.in_dest = dst; bus.in_pc = pc; bus.in_valid = 1;
        if (expw) exp_q.push_back({dst, expd});
    endtask

    task automatic complete();
        int n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin total++; $display("FAIL accept_timeout: in_ready=0 expected 1 within 20 cycles"); end
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] lmd,
                        input logic [1:0] sz, input logic un, input logic [3:0] dst, input logic [4:0] pc,
                        input logic expw, input logic [31:0] expd);
        drive(op, alu, lmd, sz, un, dst, pc, expw, expd);
        complete();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_rf_we"}, bus.rf_we, 0);
        check({tag, "_rf_addr"}, bus.rf_addr, 0);
        check({tag, "_rf_data"}, bus.rf_data, 0);
        check({tag, "_fwd"}, {fwd_valid, fwd_addr, fwd_data}, 0);
        check({tag, "_out"}, {out_pc, out_opcode}, 0);
        check({tag, "_count"}, retire_count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units");
        $fatal;
    end

    initial begin
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_alu = 0; bus.in_lmd = 0; bus.in_size = 0;
        bus.in_unsigned = 0; bus.in_dest = 0; bus.in_pc = 0; bus.rf_ready = 1;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1;

        // single ALU op: visible the cycle after accept, retired on the following edge
        send(ADD, 32'h5, 32'h0, 2'b00, 0, 4'd3, 5'd1, 1, 32'h5);
        check("alu_rf", {bus.rf_we, bus.rf_addr, bus.rf_data}, {1'b1, 4'd3, 32'h5});
        check("alu_fwd", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 4'd3, 32'h5});
        cycles(1);
        check("alu_count", retire_count, 1);
        check("alu_out", {out_pc, out_opcode}, {5'd1, ADD});
        check("alu_drained", bus.rf_we, 0);

        // load extension
        send(LDW, 32'hDEAD0000, 32'h00000080, 2'b10, 0, 4'd4, 5'd2, 1, 32'hFFFFFF80);
        send(LDW, 32'hDEAD0000, 32'h00000080, 2'b10, 1, 4'd5, 5'd3, 1, 32'h00000080);
        send(LDW, 32'hDEAD0000, 32'h00008001, 2'b01, 0, 4'd6, 5'd4, 1, 32'hFFFF8001);
        send(LDW, 32'hDEAD0000, 32'h92345678, 2'b11, 0, 4'd7, 5'd5, 1, 32'h92345678);
        cycles(2);
        check("ldw_count", retire_count, 5);

        // backpressure: two accepted, third held, head stable
        bus.rf_ready = 0;
        send(ADD, 32'h11, 32'h0, 2'b00, 0, 4'd1, 5'd2, 1, 32'h11);
        send(SUB, 32'h22, 32'h0, 2'b00, 0, 4'd2, 5'd3, 1, 32'h22);
        drive(OR, 32'h33, 32'h0, 2'b00, 0, 4'd8, 5'd4, 1, 32'h33);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_rf", {bus.rf_we, bus.rf_addr, bus.rf_data}, {1'b1, 4'd1, 32'h11});
            cycles(1);
        end
        bus.rf_ready = 1;
        complete();
        cycles(3);
        check("stall_count", retire_count, 8);
        check("stall_out", {out_pc, out_opcode}, {5'd4, OR});

        // NOP dropped, STR retires without writing
        send(NOP, 32'hAA, 32'h0, 2'b00, 0, 4'd9, 5'd5, 0, 32'h0);
        send(STR, 32'hBB, 32'h0, 2'b00, 0, 4'd9, 5'd6, 0, 32'h0);
        check("str_rf_we", {bus.rf_we, fwd_valid}, 0);
        send(XOR, 32'h44, 32'h0, 2'b00, 0, 4'd9, 5'd7, 1, 32'h44);
        check("str_retired", {retire_count, out_pc, out_opcode}, {4'd9, 5'd6, STR});
        cycles(1);
        check("seq_count", retire_count, 10);
        check("seq_out", {out_pc, out_opcode}, {5'd7, XOR});

        // flush with full buffer and an offered entry
        bus.rf_ready = 0;
        send(ADD, 32'h55, 32'h0, 2'b00, 0, 4'd10, 5'd8, 0, 32'h0);
        send(ADD, 32'h66, 32'h0, 2'b00, 0, 4'd11, 5'd9, 0, 32'h0);
        check("full_in_ready", bus.in_ready, 0);
        drive(ADD, 32'h67, 32'h0, 2'b00, 0, 4'd12, 5'd10, 0, 32'h0);
        flush = 1;
        cycles(1);
        flush = 0; bus.in_valid = 0;
        check("flush_rf_we", bus.rf_we, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_keep", {retire_count, out_pc, out_opcode}, {4'd10, 5'd7, XOR});
        bus.rf_ready = 1;
        cycles(2);
        check("flush_count", retire_count, 10);

        // flush beats a simultaneous accept on a non-full buffer
        bus.rf_ready = 0;
        send(ADD, 32'h77, 32'h0, 2'b00, 0, 4'd13, 5'd10, 0, 32'h0);
        drive(ADD, 32'h88, 32'h0, 2'b00, 0, 4'd14, 5'd11, 0, 32'h0);
        flush = 1;
        cycles(1);
        flush = 0; bus.in_valid = 0;
        check("flush2_rf_we", bus.rf_we, 0);
        bus.rf_ready = 1;
        cycles(2);
        check("flush2_count", {bus.rf_we, retire_count}, {1'b0, 4'd10});

        // counter wrap: 10 -> 15 -> 0
        for (int i = 0; i < 5; i++) send(ADD, 32'h100 + i, 32'h0, 2'b00, 0, 4'(i), 5'd20, 1, 32'h100 + i);
        cycles(2);
        check("count_15", retire_count, 15);
        send(SUB, 32'h200, 32'h0, 2'b00, 0, 4'd6, 5'd21, 1, 32'h200);
        cycles(2);
        check("count_wrap", retire_count, 0);
        check("wrap_out", {out_pc, out_opcode}, {5'd21, SUB});

        // asynchronous reset during a stall
        bus.rf_ready = 0;
        send(ADD, 32'h99, 32'h0, 2'b00, 0, 4'd15, 5'd11, 0, 32'h0);
        send(XOR, 32'h9A, 32'h0, 2'b00, 0, 4'd14, 5'd12, 0, 32'h0);
        #2 rst = 0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1;
        bus.rf_ready = 1;
        send(ADD, 32'hABC, 32'h0, 2'b00, 0, 4'd2, 5'd12, 1, 32'hABC);
        cycles(2);
        check("post_reset", {retire_count, out_pc, out_opcode}, {4'd1, 5'd12, ADD});
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_stage_buffered.md
Name: wb_stage_buffered

Overview:
- Parametrised successor to the PIGRO writeback stage.
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- Selects the ALU result or the size-extended load data as the register-file write value, and queues entries in an in-order buffer of DEPTH entries.
- Drives the register-file write port with backpressure (rf_ready), exposes the buffer head for forwarding, and counts retired instructions.

Parameters:
- DATA_W, 32: datapath width (ALU result, load data, RF write data).
- RADDR_W, 4: register-file address width.
- PC_W, 5: program-counter width.
- OP_W, 5: opcode width; values from opcodes.vh.
- DEPTH, 2: buffer entries, power of two, at least 2.
- CNT_W, 16: retire counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous: discard all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_opcode  in  OP_W  opcode of the entry.
- in_alu  in  DATA_W  ALU result.
- in_lmd  in  DATA_W  load memory data, right-aligned.
- in_size  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
- in_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- in_dest  in  RADDR_W  destination register.
- in_pc  in  PC_W  PC of the entry.
- rf_we  out  1  RF write enable.
- rf_addr  out  RADDR_W  RF write address.
- rf_data  out  DATA_W  RF write data.
- rf_ready  in  1  RF accepts the write this cycle.
- fwd_valid  out  1  head entry will write the RF.
- fwd_addr  out  RADDR_W  head destination.
- fwd_data  out  DATA_W  head write data.
- out_pc  out  PC_W  PC of the last retired entry.
- out_opcode  out  OP_W  opcode of the last retired entry.
- retire_count  out  CNT_W  number of retired entries.

Behaviour:
- Reset (rst=0, asynchronous): buffer empty; in_ready=1; rf_we=0; rf_addr, rf_data, fwd_* = 0; out_pc=0; out_opcode=0; retire_count=0.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (occupancy < DEPTH). It depends on occupancy only: a full buffer does not accept in the same cycle it retires.
- Classification at accept:
  - NOP: dropped, never enqueued, not counted.
  - ALU ops (NOP < op <= ARSH): write=1, data = in_alu.
  - LDW: write=1, data = in_lmd extended per in_size and in_unsigned (byte uses bit 7, half uses bit 15).
  - STR: write=0.
  - Any other opcode: write=0, enqueued.
- Buffer is FIFO ordered, with wrapping read/write pointers and an occupancy counter. Simultaneous enqueue and dequeue leaves occupancy unchanged.
- Head outputs (rf_*, fwd_*) come from registered buffer contents. rf_we = head valid & head write.
- Latency: an entry accepted at edge N appears on rf_* in the cycle after edge N when the buffer was empty.
- Retire (dequeue):
  - Head with write=1: retires at the edge where rf_ready=1. While rf_ready=0, rf_we, rf_addr and rf_data hold stable.
  - Head with write=0: retires at the next edge regardless of rf_ready.
  - One retire per cycle maximum.
- On retire: out_pc and out_opcode take the head values; retire_count increments by 1 and wraps from 2^CNT_W-1 to 0.
- fwd_valid = rf_we. Hazard logic must also compare against in_dest; that compare is outside this block.
- flush:
  - Clears occupancy and both pointers; rf_we=0 from the next cycle; retire_count and out_* unchanged.
  - Takes priority over accept and retire in the same cycle: neither happens.
- Empty buffer: rf_we=0; fwd_* hold the last head values and are don't-care.
- Reset asserted mid-operation: all state clears immediately; pending writes are lost.

Test Plan:
- Reset, then ALU op with in_alu=0x0000_0005, in_dest=3, rf_ready=1 -> next cycle rf_we=1, rf_addr=3, rf_data=5; following edge retire_count=1.
- LDW with in_lmd=0x0000_0080, size=byte, in_unsigned=0 -> rf_data=0xFFFF_FF80. Repeat with in_unsigned=1 -> 0x0000_0080. Half with 0x0000_8001, signed -> 0xFFFF_8001.
- rf_ready=0, three back-to-back ALU ops -> in_ready drops after 2 accepts; third held; rf_* stable. Raise rf_ready -> writes issue in order, one per cycle, count=3.
- NOP, STR, ALU sequence with rf_ready=1 -> NOP not counted, STR retires with rf_we=0, final retire_count=2, out_opcode=ALU op.
- Full buffer with rf_ready=0, assert flush together with in_valid -> occupancy 0, rf_we=0 next cycle, the offered entry not accepted, retire_count unchanged.
- retire_count preloaded near wrap via 2^CNT_W retires (CNT_W=4 build) -> value returns to 0. Pulse rst low mid-stall -> all outputs at reset values immediately.
